// File: rtl/lfsr_gen_pkg.sv
// Shared constants and configuration type for the lfsr_gen pseudo-random source.
// Instantiators pick taps/seeds from here so every LFSR in the block agrees.
package lfsr_gen_pkg;

  localparam logic [15:0] LFSR16_TAPS   = 16'hB400;
  localparam logic [15:0] LFSR16_INIT_A = 16'he45b;
  localparam logic [15:0] LFSR16_INIT_B = 16'hbeef;

  typedef struct packed {
    int unsigned width;
    logic [31:0] taps;
    int unsigned out_w;
  } lfsr_cfg_t;

  localparam lfsr_cfg_t LFSR16_CFG_DEFAULT = '{
    width: 16,
    taps:  {16'h0000, LFSR16_TAPS},
    out_w: 6
  };

endpackage

// File: rtl/lfsr_gen_step.sv
// Combinational word generator: unrolls OUT_W Fibonacci steps of a WIDTH-bit LFSR.
// The first feedback bit produced lands in the word MSB.
module lfsr_gen_step
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR16_TAPS),
  parameter int unsigned      OUT_W = 6
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_state_o,
  output logic [OUT_W-1:0] word_o
);

  logic [WIDTH-1:0] s;
  logic             fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    word_o = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      fb                = ^(s & TAPS);
      word_o[OUT_W-1-i] = fb;
      s                 = {s[WIDTH-2:0], fb};
    end
    next_state_o = s;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Multi-bit LFSR source with a valid/ready output register and runtime reseeding.
// Define LFSR_GEN_STEPCNT_EN to build the 32-bit accepted-word counter on step_cnt.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH   = 16,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(LFSR16_TAPS),
  parameter int unsigned      OUT_W   = 6,
  parameter logic [WIDTH-1:0] INITVAL = WIDTH'(LFSR16_INIT_A)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_seed,
  output logic [31:0]      step_cnt
);

  logic [WIDTH-1:0] state_q, state_d, step_state;
  logic [OUT_W-1:0] out_data_q, out_data_d, step_word;
  logic             out_valid_q, out_valid_d;
  logic             zero_seed_q, zero_seed_d;
  logic             gen_en;

  lfsr_gen_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .OUT_W (OUT_W)
  ) u_step (
    .state_i      (state_q),
    .next_state_o (step_state),
    .word_o       (step_word)
  );

  // A word is produced whenever the output register is empty or being drained.
  assign gen_en = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    zero_seed_d = zero_seed_q;
    if (seed_valid) begin
      out_valid_d = 1'b0;
      if (seed_data == '0) begin
        state_d     = INITVAL;
        zero_seed_d = 1'b1;
      end else begin
        state_d = seed_data;
      end
    end else if (gen_en) begin
      state_d     = step_state;
      out_data_d  = step_word;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INITVAL;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_seed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_seed_q <= zero_seed_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign zero_seed = zero_seed_q;

`ifdef LFSR_GEN_STEPCNT_EN
  logic [31:0] step_cnt_q, step_cnt_d;

  // A handshake completing alongside a seed load still counts.
  always_comb step_cnt_d = step_cnt_q + 32'(out_valid_q & out_ready);

  always_ff @(posedge clk) begin
    if (rst) step_cnt_q <= '0;
    else     step_cnt_q <= step_cnt_d;
  end

  assign step_cnt = step_cnt_q;
`else
  assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: two instances (1-bit and 6-bit words) against
// a spec-level model driven by the same stimulus.
module tb_lfsr_gen;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] IV_A = 16'he45b;
  localparam logic [15:0] IV_B = 16'hbeef;

  logic        clk, rst;
  logic        sv_a, sv_b, rdy_a, rdy_b;
  logic [15:0] sd_a, sd_b;
  logic [0:0]  od_a;
  logic [5:0]  od_b;
  logic        ov_a, ov_b, zs_a, zs_b;
  logic [31:0] cnt_a, cnt_b;

  int ncmp = 0;
  int nfail = 0;
  bit preload_b = 0;

  lfsr_gen #(.WIDTH(16), .TAPS(TAPS), .OUT_W(1), .INITVAL(IV_A)) dut_a (
    .clk(clk), .rst(rst), .seed_valid(sv_a), .seed_data(sd_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(rdy_a),
    .zero_seed(zs_a), .step_cnt(cnt_a)
  );

  lfsr_gen #(.WIDTH(16), .TAPS(TAPS), .OUT_W(6), .INITVAL(IV_B)) dut_b (
    .clk(clk), .rst(rst), .seed_valid(sv_b), .seed_data(sd_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(rdy_b),
    .zero_seed(zs_b), .step_cnt(cnt_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] st;
    logic [5:0]  data;
    logic        vld;
    logic        zs;
    logic [31:0] cnt;
  } mdl_t;

  mdl_t ma, mb;

  // Generate ow bits one at a time; the feedback bit is the parity of the tapped bits.
  function automatic logic [5:0] ref_word(input logic [15:0] st, input int ow,
                                          output logic [15:0] nst);
    logic [5:0] w = 0;
    logic       fb;
    for (int k = 0; k < ow; k++) begin
      fb  = ($countones(st & TAPS) % 2) == 1;
      w   = (w << 1) | 6'(fb);
      st  = (st << 1) | 16'(fb);
    end
    nst = st;
    return w;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic r, input logic sv,
                                 input logic [15:0] sd, input logic rdy,
                                 input int ow, input logic [15:0] iv);
    mdl_t n = m;
    logic [15:0] ns;
    if (r) begin
      n.st = iv; n.data = 0; n.vld = 0; n.zs = 0; n.cnt = 0;
      return n;
    end
`ifdef LFSR_GEN_STEPCNT_EN
    if (m.vld && rdy) n.cnt = m.cnt + 1;
`endif
    if (sv) begin
      n.vld = 0;
      if (sd == 0) begin n.st = iv; n.zs = 1; end
      else n.st = sd;
    end else if (!m.vld || rdy) begin
      n.data = ref_word(m.st, ow, ns);
      n.st   = ns;
      n.vld  = 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (preload_b) mb.cnt = 32'hFFFF_FFFF;
    ma = mstep(ma, rst, sv_a, sd_a, rdy_a, 1, IV_A);
    mb = mstep(mb, rst, sv_b, sd_b, rdy_b, 6, IV_B);
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; sv_a = 0; sv_b = 0; sd_a = 0; sd_b = 0; rdy_a = 0; rdy_b = 0;
    repeat (3) cyc();
    ncmp++;
    if ({ov_a, od_a, zs_a, cnt_a, dut_a.state_q} !== {1'b0, 1'b0, 1'b0, 32'd0, IV_A}) begin
      nfail++;
      $display("FAIL reset_a: v=%b d=%h z=%b c=%0d st=%h, want 0 0 0 0 %h",
               ov_a, od_a, zs_a, cnt_a, dut_a.state_q, IV_A);
    end
    ncmp++;
    if ({ov_b, od_b, zs_b, cnt_b, dut_b.state_q} !== {1'b0, 6'd0, 1'b0, 32'd0, IV_B}) begin
      nfail++;
      $display("FAIL reset_b: v=%b d=%h z=%b c=%0d st=%h, want 0 0 0 0 %h",
               ov_b, od_b, zs_b, cnt_b, dut_b.state_q, IV_B);
    end
  endtask

  task automatic test_first_word();
    rst = 0; rdy_a = 1; rdy_b = 1;
    cyc();
    ncmp++;
    if ({ov_a, od_a, dut_a.state_q} !== {1'b1, 1'b1, 16'hC8B7}) begin
      nfail++;
      $display("FAIL first_a: v=%b d=%h st=%h, want 1 1 c8b7", ov_a, od_a, dut_a.state_q);
    end
    ncmp++;
    if ({ov_b, od_b, dut_b.state_q} !== {1'b1, 6'h1B, 16'hBBDB}) begin
      nfail++;
      $display("FAIL first_b: v=%b d=%h st=%h, want 1 1b bbdb", ov_b, od_b, dut_b.state_q);
    end
  endtask

  task automatic test_stream();
    int bad_a = 0, bad_b = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      ncmp++;
      if ({ov_a, od_a, dut_a.state_q} !== {ma.vld, ma.data[0], ma.st}) begin
        nfail++; bad_a++;
        if (bad_a < 5)
          $display("FAIL stream_a[%0d]: v=%b d=%h st=%h, want %b %h %h",
                   i, ov_a, od_a, dut_a.state_q, ma.vld, ma.data[0], ma.st);
      end
      ncmp++;
      if ({ov_b, od_b} !== {1'b1, mb.data}) begin
        nfail++; bad_b++;
        if (bad_b < 5)
          $display("FAIL stream_b[%0d]: v=%b d=%h, want 1 %h", i, ov_b, od_b, mb.data);
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] s2;
    logic [5:0]  w2;
    w2 = ref_word(16'hBBDB, 6, s2);
    rst = 1; cyc();
    rst = 0; rdy_b = 0;
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      ncmp++;
      if ({ov_b, od_b, dut_b.state_q} !== {1'b1, 6'h1B, 16'hBBDB}) begin
        nfail++;
        $display("FAIL stall_hold[%0d]: v=%b d=%h st=%h, want 1 1b bbdb",
                 i, ov_b, od_b, dut_b.state_q);
      end
    end
    rdy_b = 1;
    cyc();
    ncmp++;
    if ({ov_b, od_b, dut_b.state_q} !== {1'b1, w2, s2}) begin
      nfail++;
      $display("FAIL stall_release: v=%b d=%h st=%h, want 1 %h %h",
               ov_b, od_b, dut_b.state_q, w2, s2);
    end
  endtask

  task automatic test_seed_zero();
    logic [15:0] s1;
    logic [5:0]  w1;
    w1 = ref_word(16'h0001, 6, s1);
    sv_b = 1; sd_b = 16'h0000;
    cyc();
    sv_b = 0;
    ncmp++;
    if ({ov_b, zs_b, dut_b.state_q} !== {1'b0, 1'b1, IV_B}) begin
      nfail++;
      $display("FAIL seed_zero_flush: v=%b z=%b st=%h, want 0 1 %h", ov_b, zs_b, dut_b.state_q, IV_B);
    end
    cyc();
    ncmp++;
    if ({ov_b, od_b} !== {1'b1, 6'h1B}) begin
      nfail++;
      $display("FAIL seed_zero_word: v=%b d=%h, want 1 1b", ov_b, od_b);
    end
    sv_b = 1; sd_b = 16'h0001;
    cyc();
    sv_b = 0;
    ncmp++;
    if ({ov_b, zs_b} !== {1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL seed_sticky: v=%b z=%b, want 0 1", ov_b, zs_b);
    end
    cyc();
    ncmp++;
    if ({ov_b, od_b, zs_b} !== {1'b1, w1, 1'b1}) begin
      nfail++;
      $display("FAIL seed_one_word: v=%b d=%h z=%b, want 1 %h 1", ov_b, od_b, zs_b, w1);
    end
  endtask

  task automatic test_rst_mid();
    repeat (5) begin rdy_b = 1'($urandom); cyc(); end
    rst = 1;
    cyc();
    ncmp++;
    if ({ov_b, od_b, zs_b, cnt_b, dut_b.state_q} !== {1'b0, 6'd0, 1'b0, 32'd0, IV_B}) begin
      nfail++;
      $display("FAIL rst_mid: v=%b d=%h z=%b c=%0d st=%h, want reset values",
               ov_b, od_b, zs_b, cnt_b, dut_b.state_q);
    end
    rst = 0; rdy_b = 1; cyc(); cyc();
    rst = 1; sv_b = 1; sd_b = 16'($urandom) | 16'h1;
    cyc();
    sv_b = 0;
    ncmp++;
    if ({ov_b, od_b, zs_b, cnt_b, dut_b.state_q} !== {1'b0, 6'd0, 1'b0, 32'd0, IV_B}) begin
      nfail++;
      $display("FAIL rst_seed: v=%b d=%h z=%b c=%0d st=%h, want reset values",
               ov_b, od_b, zs_b, cnt_b, dut_b.state_q);
    end
    rst = 0;
    cyc();
    ncmp++;
    if ({ov_b, od_b, dut_b.state_q} !== {1'b1, 6'h1B, 16'hBBDB}) begin
      nfail++;
      $display("FAIL rst_restart: v=%b d=%h st=%h, want 1 1b bbdb", ov_b, od_b, dut_b.state_q);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      rdy_a = 1'($urandom); rdy_b = 1'($urandom);
      sv_a  = ($urandom_range(0, 15) == 0); sv_b = ($urandom_range(0, 15) == 0);
      sd_a  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      sd_b  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cyc();
      ncmp++;
      if ({ov_a, od_a, zs_a, cnt_a, dut_a.state_q} !== {ma.vld, ma.data[0], ma.zs, ma.cnt, ma.st}) begin
        nfail++; bad++;
        if (bad < 6)
          $display("FAIL rand_a[%0d]: v=%b d=%h z=%b c=%0d st=%h, want %b %h %b %0d %h",
                   i, ov_a, od_a, zs_a, cnt_a, dut_a.state_q, ma.vld, ma.data[0], ma.zs, ma.cnt, ma.st);
      end
      ncmp++;
      if ({ov_b, od_b, zs_b, cnt_b, dut_b.state_q} !== {mb.vld, mb.data, mb.zs, mb.cnt, mb.st}) begin
        nfail++; bad++;
        if (bad < 6)
          $display("FAIL rand_b[%0d]: v=%b d=%h z=%b c=%0d st=%h, want %b %h %b %0d %h",
                   i, ov_b, od_b, zs_b, cnt_b, dut_b.state_q, mb.vld, mb.data, mb.zs, mb.cnt, mb.st);
      end
    end
    rst = 0; sv_a = 0; sv_b = 0;
  endtask

  task automatic test_stepcnt();
`ifdef LFSR_GEN_STEPCNT_EN
    int n = 0;
    rst = 1; cyc();
    rst = 0;
    while (mb.cnt < 37 && n < 1000) begin
      rdy_b = 1'($urandom);
      sv_b  = (n == 15);
      sd_b  = 16'h1234;
      if (mb.cnt == 36 && mb.vld) sv_b = 0;
      cyc();
      n++;
    end
    sv_b = 0; rdy_b = 0;
    ncmp++;
    if (n >= 1000) begin
      nfail++;
      $display("FAIL stepcnt_timeout: no 37 handshakes in %0d cycles", n);
    end else if (cnt_b !== 32'd37) begin
      nfail++;
      $display("FAIL stepcnt_37: got %0d, want 37", cnt_b);
    end
    cyc();
    preload_b = 1;
    force dut_b.step_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut_b.step_cnt_q;
    @(negedge clk);
    preload_b = 0;
    rdy_b = 1;
    cyc();
    rdy_b = 0;
    ncmp++;
    if (cnt_b !== 32'd0) begin
      nfail++;
      $display("FAIL stepcnt_wrap: got %h, want 0", cnt_b);
    end
`else
    repeat (10) begin rdy_a = 1; rdy_b = 1'($urandom); cyc(); end
    ncmp++;
    if ({cnt_a, cnt_b} !== 64'd0) begin
      nfail++;
      $display("FAIL stepcnt_tied: got %0d/%0d, want 0/0", cnt_a, cnt_b);
    end
`endif
  endtask

  initial begin
    ma = '{st: 0, data: 0, vld: 0, zs: 0, cnt: 0};
    mb = '{st: 0, data: 0, vld: 0, zs: 0, cnt: 0};
    rst = 1; sv_a = 0; sv_b = 0; sd_a = 0; sd_b = 0; rdy_a = 0; rdy_b = 0;
    @(negedge clk);
    test_reset();
    test_first_word();
    test_stream();
    test_stall();
    test_seed_zero();
    test_rst_mid();
    test_back_to_back();
    test_stepcnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
